// File: rtl/fp_pkg.sv
// Shared constants and types for the sequential floating-point units.
// Default widths describe binary32; units override them via parameters.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_W = 1 + FP_EXP_W + FP_MAN_W;
    localparam int FP_DP_W = FP_MAN_W + 5;
    localparam int FP_SHIFT_MAX = FP_MAN_W + 3;
    localparam int FP_LZC_W = FP_MAN_W + 2;

    localparam logic [FP_W-1:0] FP_QNAN =
        {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};

    localparam int FLAG_INV = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        ROUND
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_NAN,
        TAG_INF
    } tag_t;

endpackage

// File: rtl/fp_addsub_seq_if.sv
// Start/done request bundle between the issuing controller and the FP adder.
interface fp_addsub_seq_if
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
);

    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output start, op, a, b,
        input  busy, done, result, flags
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, flags
    );

endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero vector yields WIDTH.
module fp_lzc #(
    parameter int WIDTH = 25
) (
    input  logic [WIDTH-1:0]             vec,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = $clog2(WIDTH + 1);

    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) count = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 adder/subtractor, fixed 5-cycle latency,
// round-to-nearest-even with subnormal support and exception flags.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic            clk,
    input  logic            reset,
    fp_addsub_seq_if.slave  bus
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int DW   = MAN_W + 5;
    localparam int SMAX = MAN_W + 3;
    localparam int LZW  = MAN_W + 2;
    localparam int CW   = $clog2(LZW + 1);
    localparam int EXW  = EXP_W + 1;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN =
        {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    state_t state, state_nx;

    logic [W-1:0]     ra, rb;
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W:0]   ma, mb;
    tag_t             tag;
    logic             tag_sign;
    logic [DW-1:0]    mx, my, ms;
    logic [EXW-1:0]   ex, en;
    logic             sx, sub, both_neg;
    logic [DW-2:0]    mn;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = UNPACK;
            UNPACK:  state_nx = ALIGN;
            ALIGN:   state_nx = ADD;
            ADD:     state_nx = NORM;
            NORM:    state_nx = ROUND;
            ROUND:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    logic [EXP_W-1:0] fa_e, fb_e;
    logic fa_z, fb_z, fa_nan, fb_nan, fa_inf, fb_inf;

    always_comb begin
        fa_e   = ra[W-2 -: EXP_W];
        fb_e   = rb[W-2 -: EXP_W];
        fa_z   = (fa_e == '0);
        fb_z   = (fb_e == '0);
        fa_nan = (fa_e == EMAX) && (ra[MAN_W-1:0] != '0);
        fb_nan = (fb_e == EMAX) && (rb[MAN_W-1:0] != '0);
        fa_inf = (fa_e == EMAX) && (ra[MAN_W-1:0] == '0);
        fb_inf = (fb_e == EMAX) && (rb[MAN_W-1:0] == '0);
    end

    logic             a_big, s_big;
    logic [EXP_W-1:0] e_big, e_sml;
    logic [MAN_W:0]   m_big, m_sml;
    logic [31:0]      diff, sh;
    logic [2*DW-1:0]  wide;
    logic [DW-1:0]    aligned;

    // The smaller operand is shifted in a double-width window so every
    // bit that falls off the right edge can be folded into sticky.
    always_comb begin
        a_big   = {ea, ma} >= {eb, mb};
        e_big   = a_big ? ea : eb;
        e_sml   = a_big ? eb : ea;
        m_big   = a_big ? ma : mb;
        m_sml   = a_big ? mb : ma;
        s_big   = a_big ? sa : sb;
        diff    = 32'(e_big - e_sml);
        sh      = (diff > 32'(SMAX)) ? 32'(SMAX) : diff;
        wide    = {1'b0, m_sml, 3'b000, {DW{1'b0}}} >> sh;
        aligned = wide[2*DW-1:DW]
                | {{(DW-1){1'b0}}, |wide[DW-1:0]};
    end

    logic [CW-1:0]  lz;
    logic [EXW-1:0] lz_e, lim, nsh, n_e;
    logic [DW-2:0]  n_m;

    fp_lzc #(.WIDTH(LZW)) u_lzc (
        .vec   (ms[DW-2:2]),
        .count (lz)
    );

    // Left shift stops at exponent 1 so tiny results stay subnormal.
    always_comb begin
        lz_e = EXW'(lz);
        lim  = ex - EXW'(1);
        nsh  = (lz_e < lim) ? lz_e : lim;
        if (ms[DW-1]) begin
            n_m = {ms[DW-1:2], |ms[1:0]};
            n_e = ex + EXW'(1);
        end else begin
            n_m = ms[DW-2:0] << nsh;
            n_e = ex - nsh;
        end
    end

    logic             rg, rr, rs, up, hid, inx, sgn;
    logic [MAN_W+1:0] mr;
    logic [MAN_W-1:0] frac;
    logic [EXW-1:0]   er;
    logic [W-1:0]     r_word;
    logic [3:0]       r_flags;

    always_comb begin
        rg = mn[2];
        rr = mn[1];
        rs = mn[0];
        up = rg & (rr | rs | mn[3]);
        mr = {1'b0, mn[DW-2:3]} + (MAN_W+2)'(up);
        if (mr[MAN_W+1]) begin
            hid  = 1'b1;
            frac = '0;
            er   = en + EXW'(1);
        end else begin
            hid  = mr[MAN_W];
            frac = mr[MAN_W-1:0];
            er   = en;
        end
        inx = rg | rr | rs;
        sgn = (mn == '0) ? both_neg : sx;
        r_word = {sgn, hid ? er[EXP_W-1:0] : {EXP_W{1'b0}}, frac};
        r_flags = '0;
        r_flags[FLAG_INX] = inx;
        r_flags[FLAG_UNF] = ~hid & inx;
        if (hid && (er >= EXW'(EMAX))) begin
            r_word = {sgn, EMAX, {MAN_W{1'b0}}};
            r_flags = '0;
            r_flags[FLAG_OVF] = 1'b1;
            r_flags[FLAG_INX] = 1'b1;
        end
        if (tag == TAG_NAN) begin
            r_word = QNAN;
            r_flags = '0;
            r_flags[FLAG_INV] = 1'b1;
        end else if (tag == TAG_INF) begin
            r_word = {tag_sign, EMAX, {MAN_W{1'b0}}};
            r_flags = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.flags  <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    ra <= bus.a;
                    rb <= {bus.b[W-1] ^ bus.op, bus.b[W-2:0]};
                end
                UNPACK: begin
                    sa <= ra[W-1];
                    sb <= rb[W-1];
                    ea <= fa_z ? EXP_W'(1) : fa_e;
                    eb <= fb_z ? EXP_W'(1) : fb_e;
                    ma <= {~fa_z, ra[MAN_W-1:0]};
                    mb <= {~fb_z, rb[MAN_W-1:0]};
                    tag_sign <= fa_inf ? ra[W-1] : rb[W-1];
                    if (fa_nan | fb_nan
                        | (fa_inf & fb_inf & (ra[W-1] ^ rb[W-1])))
                        tag <= TAG_NAN;
                    else if (fa_inf | fb_inf)
                        tag <= TAG_INF;
                    else
                        tag <= TAG_NONE;
                end
                ALIGN: begin
                    mx       <= {1'b0, m_big, 3'b000};
                    my       <= aligned;
                    ex       <= {1'b0, e_big};
                    sx       <= s_big;
                    sub      <= sa ^ sb;
                    both_neg <= sa & sb;
                end
                ADD: ms <= sub ? mx - my : mx + my;
                NORM: begin
                    mn <= n_m;
                    en <= n_e;
                end
                ROUND: begin
                    bus.result <= r_word;
                    bus.flags  <= r_flags;
                    bus.done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
